// File: rtl/hdmi_island_scheduler_if.sv
// Bundle between the pixel timing counters / packet sources and the island scheduler.
// The master side drives position and requests; the slave side returns period and packet info.
interface hdmi_island_scheduler_if;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [9:0] screen_start_x;
  logic [9:0] screen_start_y;
  logic       acr_req;
  logic       audio_req;
  logic [2:0] mode;
  logic [1:0] packet_sel;
  logic [4:0] pkt_cycle;
  logic       packet_start;
  logic       acr_ack;
  logic       avi_ack;
  logic       aif_ack;
  logic       audio_ack;

  modport master (
    output cx, cy, screen_start_x, screen_start_y, acr_req, audio_req,
    input  mode, packet_sel, pkt_cycle, packet_start,
    input  acr_ack, avi_ack, aif_ack, audio_ack
  );

  modport slave (
    input  cx, cy, screen_start_x, screen_start_y, acr_req, audio_req,
    output mode, packet_sel, pkt_cycle, packet_start,
    output acr_ack, avi_ack, aif_ack, audio_ack
  );
endinterface

// File: rtl/hdmi_island_scheduler.sv
// HDMI period sequencer: control / video / data-island periods plus packet arbitration.
// Define HDMI_DVI_MODE_EN for a DVI-only build (no data islands, no pending logic).
//   state    | meaning
//   S_IDLE   | control or video period; island may open at cx == DI_START_X
//   S_PRE    | island preamble, remaining 7 of 8 cycles (first is the IDLE start cycle)
//   S_LGUARD | leading island guard band, 2 cycles
//   S_PKT    | one 32-cycle packet, pkt_cycle 0..31
//   S_TGUARD | trailing island guard band, 2 cycles
module hdmi_island_scheduler #(
  parameter int DI_START_X  = 10,
  parameter int MAX_PACKETS = 18
) (
  input logic                    clk_pixel,
  input logic                    reset_n,
  hdmi_island_scheduler_if.slave bus
);

  localparam logic [2:0] M_CTRL       = 3'd0;
  localparam logic [2:0] M_VID_PRE    = 3'd1;
  localparam logic [2:0] M_VID_GUARD  = 3'd2;
  localparam logic [2:0] M_VID_ACTIVE = 3'd3;
  localparam logic [2:0] M_DI_PRE     = 3'd4;
  localparam logic [2:0] M_DI_GUARD   = 3'd5;
  localparam logic [2:0] M_DI_DATA    = 3'd6;

  localparam logic [1:0] P_ACR   = 2'd0;
  localparam logic [1:0] P_AVI   = 2'd1;
  localparam logic [1:0] P_AIF   = 2'd2;
  localparam logic [1:0] P_AUDIO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LGUARD,
    S_PKT,
    S_TGUARD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  tmr_q, tmr_d;
  logic [4:0]  pc_q, pc_d;
  logic [4:0]  sent_q, sent_d;
  logic [4:0]  nmax_q, nmax_d;
  logic [4:0]  nmax_c;

  logic        acr_pend_q, avi_pend_q, aif_pend_q;
  logic        any_pend, start_ok, more;
  logic        island, pkt_start;
  logic [2:0]  di_mode, vid_mode;
  logic [1:0]  winner;
  logic        acr_hit, avi_hit, aif_hit, audio_hit;

  // Island budget: space left before the video preamble after the fixed island overhead.
  logic signed [11:0] avail;
  logic        [5:0]  blocks;

  assign avail  = $signed({2'b00, bus.screen_start_x}) - $signed(12'(DI_START_X + 34));
  assign blocks = avail[10:5];

  always_comb begin
    nmax_c = 5'd0;
    if (avail <= 12'sd0)
      nmax_c = 5'd0;
    else if (blocks > 6'(MAX_PACKETS))
      nmax_c = 5'(MAX_PACKETS);
    else
      nmax_c = blocks[4:0];
  end

  logic [10:0] cx_w, ssx_w;
  assign cx_w  = {1'b0, bus.cx};
  assign ssx_w = {1'b0, bus.screen_start_x};

  always_comb begin
    vid_mode = M_CTRL;
    if (bus.cy >= bus.screen_start_y) begin
      if (cx_w >= ssx_w)
        vid_mode = M_VID_ACTIVE;
      else if (cx_w + 11'd2 >= ssx_w)
        vid_mode = M_VID_GUARD;
      else if (cx_w + 11'd10 >= ssx_w)
        vid_mode = M_VID_PRE;
    end
  end

  always_comb begin
    winner = P_AUDIO;
    if (acr_pend_q)
      winner = P_ACR;
    else if (avi_pend_q)
      winner = P_AVI;
    else if (aif_pend_q)
      winner = P_AIF;
  end

  assign any_pend  = acr_pend_q | avi_pend_q | aif_pend_q | bus.audio_req;
  assign more      = (sent_q < nmax_q) && any_pend;

  assign acr_hit   = pkt_start && (winner == P_ACR);
  assign avi_hit   = pkt_start && (winner == P_AVI);
  assign aif_hit   = pkt_start && (winner == P_AIF);
  assign audio_hit = pkt_start && (winner == P_AUDIO) && bus.audio_req;

`ifdef HDMI_DVI_MODE_EN
  assign acr_pend_q = 1'b0;
  assign avi_pend_q = 1'b0;
  assign aif_pend_q = 1'b0;
  assign start_ok   = 1'b0;
`else
  logic frame_start;
  assign frame_start = (bus.cx == 10'd0) && (bus.cy == 10'd0);
  assign start_ok    = (bus.cx == 10'(DI_START_X)) && (nmax_c != 5'd0) && any_pend;

  // A request in the same cycle as its ack re-arms the flag (set wins over clear).
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_pend_q <= 1'b0;
      avi_pend_q <= 1'b0;
      aif_pend_q <= 1'b0;
    end else begin
      acr_pend_q <= bus.acr_req | (acr_pend_q & ~acr_hit);
      avi_pend_q <= frame_start | (avi_pend_q & ~avi_hit);
      aif_pend_q <= frame_start | (aif_pend_q & ~aif_hit);
    end
  end
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= 3'd0;
      pc_q    <= 5'd0;
      sent_q  <= 5'd0;
      nmax_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pc_q    <= pc_d;
      sent_q  <= sent_d;
      nmax_q  <= nmax_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pc_d      = pc_q;
    sent_d    = sent_q;
    nmax_d    = nmax_q;
    island    = 1'b0;
    di_mode   = M_CTRL;
    pkt_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          island  = 1'b1;
          di_mode = M_DI_PRE;
          state_d = S_PRE;
          tmr_d   = 3'd6;
          sent_d  = 5'd0;
          nmax_d  = nmax_c;
        end
      end
      S_PRE: begin
        island  = 1'b1;
        di_mode = M_DI_PRE;
        if (tmr_q == 3'd0) begin
          state_d = S_LGUARD;
          tmr_d   = 3'd1;
        end else begin
          tmr_d = tmr_q - 3'd1;
        end
      end
      S_LGUARD: begin
        island  = 1'b1;
        di_mode = M_DI_GUARD;
        if (tmr_q == 3'd0) begin
          if (more) begin
            state_d = S_PKT;
            pc_d    = 5'd0;
          end else begin
            state_d = S_TGUARD;
            tmr_d   = 3'd1;
          end
        end else begin
          tmr_d = tmr_q - 3'd1;
        end
      end
      S_PKT: begin
        island  = 1'b1;
        di_mode = M_DI_DATA;
        if (pc_q == 5'd0) begin
          pkt_start = 1'b1;
          sent_d    = sent_q + 5'd1;
        end
        pc_d = pc_q + 5'd1;
        if (pc_q == 5'd31 && !more) begin
          state_d = S_TGUARD;
          tmr_d   = 3'd1;
          pc_d    = 5'd0;
        end
      end
      S_TGUARD: begin
        island  = 1'b1;
        di_mode = M_DI_GUARD;
        if (tmr_q == 3'd0)
          state_d = S_IDLE;
        else
          tmr_d = tmr_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      bus.mode         <= M_CTRL;
      bus.packet_sel   <= P_ACR;
      bus.pkt_cycle    <= 5'd0;
      bus.packet_start <= 1'b0;
      bus.acr_ack      <= 1'b0;
      bus.avi_ack      <= 1'b0;
      bus.aif_ack      <= 1'b0;
      bus.audio_ack    <= 1'b0;
    end else begin
      bus.mode         <= island ? di_mode : vid_mode;
      if (pkt_start)
        bus.packet_sel <= winner;
      bus.pkt_cycle    <= (state_q == S_PKT) ? pc_q : 5'd0;
      bus.packet_start <= pkt_start;
      bus.acr_ack      <= acr_hit;
      bus.avi_ack      <= avi_hit;
      bus.aif_ack      <= aif_hit;
      bus.audio_ack    <= audio_hit;
    end
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler: per-pixel scoreboard of expected period/packet outputs
// built from a position-based island plan, plus ack tallies for the scenario checks.
module tb_hdmi_island_scheduler;
  localparam int DI_X = 10;
  localparam int MAXP = 18;
`ifdef HDMI_DVI_MODE_EN
  localparam bit DVI = 1'b1;
`else
  localparam bit DVI = 1'b0;
`endif

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  hdmi_island_scheduler_if bus();

  hdmi_island_scheduler #(.DI_START_X(DI_X), .MAX_PACKETS(MAXP)) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  int ssx_v, ssy_v;
  bit m_acr, m_avi, m_aif, m_isl;
  int m_off, m_k, m_nmax, m_tg;
  logic [1:0] m_sel;
  int n_acr, n_avi, n_aif, n_aud, n_di;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nmax_of(input int ssx);
    int a;
    a = ssx - DI_X - 34;
    if (DVI || a <= 0) return 0;
    return (a / 32 > MAXP) ? MAXP : a / 32;
  endfunction

  function automatic logic [2:0] vid_of(input int x, input int y, input int ssx, input int ssy);
    if (y < ssy) return 3'd0;
    if (x >= ssx) return 3'd3;
    if (x >= ssx - 2) return 3'd2;
    if (x >= ssx - 10) return 3'd1;
    return 3'd0;
  endfunction

  task automatic model_clear();
    m_acr = 0; m_avi = 0; m_aif = 0; m_isl = 0;
    m_off = 0; m_k = 0; m_nmax = 0; m_tg = -1; m_sel = 2'd0;
  endtask

  task automatic pixel(input int x, input int y, input bit acr, input bit aud);
    logic [2:0] em;
    logic [1:0] es;
    logic [4:0] epc;
    logic       eps;
    logic [3:0] ea;
    logic [14:0] obs, exp;
    bit anyp;
    int pc;
    @(negedge clk_pixel);
    bus.cx = 10'(x); bus.cy = 10'(y);
    bus.screen_start_x = 10'(ssx_v); bus.screen_start_y = 10'(ssy_v);
    bus.acr_req = acr; bus.audio_req = aud;
    em = vid_of(x, y, ssx_v, ssy_v); epc = 5'd0; eps = 1'b0; ea = 4'd0;
    anyp = m_acr | m_avi | m_aif | aud;
    if (!m_isl && x == DI_X && nmax_of(ssx_v) > 0 && anyp) begin
      m_isl = 1; m_off = 0; m_k = 0; m_nmax = nmax_of(ssx_v); m_tg = -1;
    end
    if (m_isl) begin
      if (m_off < 8) em = 3'd4;
      else if (m_off < 10) begin
        em = 3'd5;
        if (m_off == 9 && !(m_k < m_nmax && anyp)) m_tg = 10;
      end else if (m_tg >= 0) em = 3'd5;
      else begin
        em = 3'd6; pc = (m_off - 10) % 32; epc = 5'(pc);
        if (pc == 0) begin
          eps = 1'b1; m_k++;
          if (m_acr) begin m_sel = 2'd0; ea = 4'b1000; end
          else if (m_avi) begin m_sel = 2'd1; ea = 4'b0100; end
          else if (m_aif) begin m_sel = 2'd2; ea = 4'b0010; end
          else begin m_sel = 2'd3; ea = aud ? 4'b0001 : 4'b0000; end
        end
        if (pc == 31 && !(m_k < m_nmax && anyp)) m_tg = m_off + 1;
      end
      if (m_tg >= 0 && m_off == m_tg + 1) m_isl = 0;
      m_off++;
    end
    es = (em == 3'd6) ? m_sel : 2'd0;
    exp_q.push_back({em, es, epc, eps, ea});
    if (ea[3]) m_acr = 0;
    if (acr) m_acr = 1;
    if (ea[2]) m_avi = 0;
    if (ea[1]) m_aif = 0;
    if (x == 0 && y == 0) begin m_avi = 1; m_aif = 1; end
    @(posedge clk_pixel); #1;
    obs = {bus.mode, (bus.mode == 3'd6) ? bus.packet_sel : 2'd0, bus.pkt_cycle, bus.packet_start,
           bus.acr_ack, bus.avi_ack, bus.aif_ack, bus.audio_ack};
    n_acr += int'(bus.acr_ack); n_avi += int'(bus.avi_ack);
    n_aif += int'(bus.aif_ack); n_aud += int'(bus.audio_ack);
    if (bus.mode >= 3'd4) n_di++;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk($sformatf("px(%0d,%0d)", x, y), 32'(obs), 32'(exp));
    end
  endtask

  task automatic line(input int y, input int w, input int acr_at, input int acr2_at, input bit aud);
    for (int x = 0; x < w; x++)
      pixel(x, y, (x == acr_at) || (x == acr2_at), aud);
  endtask

  initial begin
    int a0, v0, f0, d0;
    bus.cx = '0; bus.cy = '0; bus.screen_start_x = 10'd160; bus.screen_start_y = 10'd0;
    bus.acr_req = 1'b0; bus.audio_req = 1'b0;
    n_acr = 0; n_avi = 0; n_aif = 0; n_aud = 0; n_di = 0;
    ssx_v = 160; ssy_v = 0;
    model_clear();
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_pkt_cycle", 32'(bus.pkt_cycle), 32'd0);
    chk("rst_acks", 32'({bus.packet_start, bus.acr_ack, bus.avi_ack, bus.aif_ack, bus.audio_ack}), 32'd0);
    @(negedge clk_pixel);
    reset_n = 1'b1;

    // Frame start + ACR pulse: ACR, AVI, AIF island, video preamble afterwards.
    a0 = n_acr; v0 = n_avi; f0 = n_aif;
    line(0, 200, 2, -1, 1'b0);
    chk("line0_acr_acks", 32'(n_acr - a0), DVI ? 32'd0 : 32'd1);
    chk("line0_avi_acks", 32'(n_avi - v0), DVI ? 32'd0 : 32'd1);
    chk("line0_aif_acks", 32'(n_aif - f0), DVI ? 32'd0 : 32'd1);

    // Audio held over five lines, some in vertical blanking.
    ssy_v = 3;
    a0 = n_aud;
    for (int y = 1; y <= 5; y++) line(y, 200, -1, -1, 1'b1);
    chk("audio_acks_5_lines", 32'(n_aud - a0), DVI ? 32'd0 : 32'd15);

    // ACR re-requested while its ack is showing: served twice.
    a0 = n_acr;
    line(6, 200, 2, 21, 1'b0);
    chk("acr_rearm_acks", 32'(n_acr - a0), DVI ? 32'd0 : 32'd2);

    // Reset asserted at pkt_cycle 13 of the first packet.
    for (int x = 0; x <= 33; x++) pixel(x, 7, x == 2, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_mode", 32'(bus.mode), 32'd0);
    chk("midrst_pkt_cycle", 32'(bus.pkt_cycle), 32'd0);
    chk("midrst_sel", 32'(bus.packet_sel), 32'd0);
    chk("midrst_acks", 32'({bus.packet_start, bus.acr_ack, bus.avi_ack, bus.aif_ack, bus.audio_ack}), 32'd0);
    model_clear();
    exp_q.delete();
    @(negedge clk_pixel);
    reset_n = 1'b1;
    d0 = n_di;
    line(8, 200, -1, -1, 1'b0);
    line(9, 200, -1, -1, 1'b0);
    chk("post_reset_no_island", 32'(n_di - d0), 32'd0);
    v0 = n_avi;
    line(0, 200, -1, -1, 1'b0);
    chk("rearm_avi_acks", 32'(n_avi - v0), DVI ? 32'd0 : 32'd1);

    // Tiny horizontal blanking: no budget, no island.
    ssx_v = 40;
    d0 = n_di; a0 = n_aud;
    line(0, 80, 2, -1, 1'b1);
    chk("ssx40_no_island", 32'(n_di - d0), 32'd0);
    chk("ssx40_no_audio", 32'(n_aud - a0), 32'd0);

    // Pendings left from the short line get served once budget returns.
    ssx_v = 160;
    a0 = n_acr;
    line(3, 200, -1, -1, 1'b0);
    chk("held_acr_served", 32'(n_acr - a0), DVI ? 32'd0 : 32'd1);

    // Budget edges: exactly one packet, just under one packet, and the packet cap.
    a0 = n_aud;
    ssx_v = 76;  line(4, 100, -1, -1, 1'b1);
    chk("ssx76_one_packet", 32'(n_aud - a0), DVI ? 32'd0 : 32'd1);
    a0 = n_aud;
    ssx_v = 75;  line(4, 100, -1, -1, 1'b1);
    chk("ssx75_no_packet", 32'(n_aud - a0), 32'd0);
    a0 = n_aud;
    ssx_v = 700; line(5, 720, -1, -1, 1'b1);
    chk("ssx700_capped", 32'(n_aud - a0), DVI ? 32'd0 : 32'd18);

    if (DVI) chk("dvi_no_island_total", 32'(n_di), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
